tlul_host_req_queue: RTL

Host-side request/response buffer that sits directly upstream of the TL-UL host adapter. It accepts word accesses from a core over a valid/ready interface and queues them in a request FIFO. It issues them on the adapter's req/gnt interface and captures adapter responses into a response FIFO. It enforces the adapter's outstanding-request limit with a credit counter, and reserves a response slot for every granted request, because the adapter ties `d_ready` high and responses cannot be stalled.

---
 rtl/tlul_host_q_pkg.sv | 17 +
 rtl/top_pkg.sv | 6 +
 rtl/tlul_host_q_fifo.sv | 71 +++++++
 rtl/tlul_host_req_queue.sv | 125 ++++++++++++
 4 files changed

// File: rtl/tlul_host_q_pkg.sv
// Entry formats carried by the host request/response queues.
package tlul_host_q_pkg;
  typedef struct packed {
    logic [top_pkg::TL_AW-1:0]  addr;
    logic                       we;
    logic [top_pkg::TL_DW-1:0]  wdata;
    logic [top_pkg::TL_DBW-1:0] be;
  } req_entry_t;

  typedef struct packed {
    logic [top_pkg::TL_DW-1:0] rdata;
    logic                      err;
  } rsp_entry_t;

  localparam int ReqEntryW = $bits(req_entry_t);
  localparam int RspEntryW = $bits(rsp_entry_t);
endpackage

// File: rtl/top_pkg.sv
// TL-UL bus geometry shared across the host-side blocks.
package top_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
endpackage

// File: rtl/tlul_host_q_fifo.sv
// Synchronous FIFO with count-based full/empty; the head reads as zero while empty.
module tlul_host_q_fifo #(
  parameter int Width = 8,
  parameter int Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] cnt_o
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  // No pass-through: a push into a full FIFO is refused even if it pops this cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop_ok) begin
      rptr_d = ptr_inc(rptr_q);
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/tlul_host_req_queue.sv
// Core-side request/response buffer ahead of the TL-UL host adapter, with
// credit-based issue so every granted request owns a response slot.
module tlul_host_req_queue
  import tlul_host_q_pkg::*;
#(
  parameter int ReqDepth = 2,
  parameter int MaxReqs  = 2,
  parameter int CntW     = $clog2(MaxReqs + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        core_req_valid_i,
  output logic                        core_req_ready_o,
  input  logic [top_pkg::TL_AW-1:0]   core_addr_i,
  input  logic                        core_we_i,
  input  logic [top_pkg::TL_DW-1:0]   core_wdata_i,
  input  logic [top_pkg::TL_DBW-1:0]  core_be_i,
  output logic                        core_rsp_valid_o,
  input  logic                        core_rsp_ready_i,
  output logic [top_pkg::TL_DW-1:0]   core_rsp_rdata_o,
  output logic                        core_rsp_err_o,
  output logic                        req_o,
  input  logic                        gnt_i,
  output logic [top_pkg::TL_AW-1:0]   addr_o,
  output logic                        we_o,
  output logic [top_pkg::TL_DW-1:0]   wdata_o,
  output logic [top_pkg::TL_DBW-1:0]  be_o,
  input  logic                        valid_i,
  input  logic [top_pkg::TL_DW-1:0]   rdata_i,
  input  logic                        err_i,
  output logic [CntW-1:0]             inflight_o,
  output logic                        idle_o,
  output logic                        unexp_rsp_o
);
  req_entry_t req_wentry, req_head;
  rsp_entry_t rsp_wentry, rsp_head;
  logic       req_full, req_empty, rsp_full, rsp_empty;
  logic [$clog2(ReqDepth+1)-1:0] req_cnt;
  logic [CntW-1:0] rsp_cnt, outstanding;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic            unexp_q, unexp_d;
  logic            req_push, grant, rsp_push, rsp_pop;

  assign req_wentry = '{addr: core_addr_i, we: core_we_i, wdata: core_wdata_i, be: core_be_i};
  assign req_push   = core_req_valid_i && !req_full;

  tlul_host_q_fifo #(.Width(ReqEntryW), .Depth(ReqDepth)) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_push),
    .wdata_i (req_wentry),
    .pop_i   (grant),
    .rdata_o (req_head),
    .full_o  (req_full),
    .empty_o (req_empty),
    .cnt_o   (req_cnt)
  );

  // Issue only while a credit is free; inflight_q cannot rise without a grant,
  // so a raised req_o holds with stable fields until granted.
  assign req_o   = !req_empty && (inflight_q < CntW'(MaxReqs));
  assign grant   = req_o && gnt_i;
  assign addr_o  = req_head.addr;
  assign we_o    = req_head.we;
  assign wdata_o = req_head.wdata;
  assign be_o    = req_head.be;

  // Responses are only accepted for granted requests not already buffered.
  assign outstanding = inflight_q - rsp_cnt;
  assign rsp_push    = valid_i && (outstanding != '0);
  assign rsp_wentry  = '{rdata: rdata_i, err: err_i};
  assign rsp_pop     = core_rsp_valid_o && core_rsp_ready_i;

  tlul_host_q_fifo #(.Width(RspEntryW), .Depth(MaxReqs)) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rsp_push),
    .wdata_i (rsp_wentry),
    .pop_i   (rsp_pop),
    .rdata_o (rsp_head),
    .full_o  (rsp_full),
    .empty_o (rsp_empty),
    .cnt_o   (rsp_cnt)
  );

  assign core_req_ready_o = !req_full;
  assign core_rsp_valid_o = !rsp_empty;
  assign core_rsp_rdata_o = rsp_head.rdata;
  assign core_rsp_err_o   = rsp_head.err;
  assign inflight_o       = inflight_q;
  assign idle_o           = req_empty && rsp_empty && (inflight_q == '0);
  assign unexp_rsp_o      = unexp_q;

  always_comb begin
    inflight_d = inflight_q;
    unexp_d    = unexp_q;
    case ({grant, rsp_pop})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
    if (valid_i && (outstanding == '0)) begin
      unexp_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      unexp_q    <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      unexp_q    <= unexp_d;
    end
  end

  a_inflight_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    inflight_q <= CntW'(MaxReqs));
  a_req_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_cnt <= ($clog2(ReqDepth+1))'(ReqDepth));
  a_rsp_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_push |-> !rsp_full);
  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_o && !gnt_i |=> req_o && $stable(req_head));
endmodule
